// File: rtl/multicycle_sequencer.sv
// Control sequencer for the multi-cycle 32-bit datapath.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the per-stage
// enables and the memory handshakes, counts retired instructions and parks in
// HALT after an instruction whose stop bit was set.
//
// Handshake rule (both memories): the sequencer holds req high until it samples
// ready=1 on a rising edge while req is high; that edge completes the transfer.
// A ready seen while req is low has no effect.
module multicycle_sequencer #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         pcSrc,
  input  logic               mem_R,
  input  logic               mem_W,
  input  logic               regW,
  input  logic               stop,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               ir_write,
  output logic               reg_read_en,
  output logic               alu_en,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic               reg_write_en,
  output logic               pc_write,
  output logic [1:0]         pc_sel,
  output logic               instr_retired,
  output logic [COUNT_W-1:0] retired_count,
  output logic               halted,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t             cur_state;
  state_t             nxt_state;
  logic [1:0]         pc_src_q;
  logic               mem_r_q;
  logic               mem_w_q;
  logic               reg_w_q;
  logic               stop_q;
  logic               retire;
  logic [1:0]         retire_sel;
  logic [COUNT_W-1:0] count_q;

  assign state         = cur_state;
  assign retired_count = count_q;

  // State register, class latch on leaving DECODE, saturating retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= S_IDLE;
      pc_src_q  <= 2'b00;
      mem_r_q   <= 1'b0;
      mem_w_q   <= 1'b0;
      reg_w_q   <= 1'b0;
      stop_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == S_DECODE) begin
        pc_src_q <= pcSrc;
        mem_r_q  <= mem_R;
        mem_w_q  <= mem_W;
        reg_w_q  <= regW;
        stop_q   <= stop;
      end
      if (retire && (count_q != {COUNT_W{1'b1}})) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  // Next-state selection and stage enables; retire may happen in EXEC, MEM or WB.
  always_comb begin
    nxt_state    = cur_state;
    imem_req     = 1'b0;
    ir_write     = 1'b0;
    reg_read_en  = 1'b0;
    alu_en       = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    reg_write_en = 1'b0;
    halted       = 1'b0;
    retire       = 1'b0;
    retire_sel   = 2'b00;
    case (cur_state)
      S_IDLE: begin
        if (start) nxt_state = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
        if (imem_ready) nxt_state = S_DECODE;
      end
      S_DECODE: begin
        reg_read_en = 1'b1;
        nxt_state   = S_EXEC;
      end
      S_EXEC: begin
        alu_en = 1'b1;
        if (pc_src_q != 2'b00) begin
          retire     = 1'b1;
          retire_sel = pc_src_q;
        end else if (mem_r_q || mem_w_q) begin
          nxt_state = S_MEM;
        end else if (reg_w_q) begin
          nxt_state = S_WB;
        end else begin
          retire = 1'b1;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = mem_w_q;
        if (dmem_ready) begin
          // A load that is also flagged as a store behaves as a store: no WB.
          if (mem_r_q && !mem_w_q && reg_w_q) nxt_state = S_WB;
          else                                retire    = 1'b1;
        end
      end
      S_WB: begin
        reg_write_en = 1'b1;
        retire       = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
    if (retire) nxt_state = stop_q ? S_HALT : S_FETCH;
  end

  assign pc_write      = retire;
  assign instr_retired = retire;
  assign pc_sel        = retire_sel;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed and random instructions, each
// expanded by a path model into the expected per-cycle stage list.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  pc_src;
  logic        mem_r;
  logic        mem_w;
  logic        reg_w;
  logic        stop;
  logic        imem_ready;
  logic        dmem_ready;

  logic        imem_req, ir_write, reg_read_en, alu_en, dmem_req, dmem_we;
  logic        reg_write_en, pc_write, instr_retired, halted;
  logic [1:0]  pc_sel;
  logic [15:0] retired_count;
  logic [2:0]  state;

  logic        s_imem_req, s_ir_write, s_reg_read_en, s_alu_en, s_dmem_req, s_dmem_we;
  logic        s_reg_write_en, s_pc_write, s_instr_retired, s_halted;
  logic [1:0]  s_pc_sel;
  logic [1:0]  s_retired_count;
  logic [2:0]  s_state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int model_count = 0;
  logic [2:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  multicycle_sequencer #(.COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .pcSrc(pc_src), .mem_R(mem_r),
    .mem_W(mem_w), .regW(reg_w), .stop(stop), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_write(ir_write),
    .reg_read_en(reg_read_en), .alu_en(alu_en), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .reg_write_en(reg_write_en), .pc_write(pc_write),
    .pc_sel(pc_sel), .instr_retired(instr_retired), .retired_count(retired_count),
    .halted(halted), .state(state)
  );

  multicycle_sequencer #(.COUNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .start(start), .pcSrc(pc_src), .mem_R(mem_r),
    .mem_W(mem_w), .regW(reg_w), .stop(stop), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .imem_req(s_imem_req), .ir_write(s_ir_write),
    .reg_read_en(s_reg_read_en), .alu_en(s_alu_en), .dmem_req(s_dmem_req),
    .dmem_we(s_dmem_we), .reg_write_en(s_reg_write_en), .pc_write(s_pc_write),
    .pc_sel(s_pc_sel), .instr_retired(s_instr_retired), .retired_count(s_retired_count),
    .halted(s_halted), .state(s_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] small_count(input int n);
    return (n > 3) ? 32'd3 : n;
  endfunction

  // Counter checks shared by every step.
  task automatic chk_counts();
    chk("retired_count", 32'(retired_count), model_count);
    chk("small_count", 32'(s_retired_count), small_count(model_count));
  endtask

  // Runs one instruction. Class inputs carry the real values only in DECODE and
  // random garbage elsewhere; readies are random outside their request stage.
  // abort_at >= 0 asserts reset in that cycle of the instruction.
  task automatic run_instr(input logic [1:0] p, input logic mr, input logic mw,
                           input logic rw, input logic st, input int iw,
                           input int dw, input int abort_at);
    logic [2:0] es;
    logic       br, wb, last, aborted;
    int         k, fi, mi;
    br = (p != 2'b00);
    wb = !br && rw && !mw;
    for (int i = 0; i <= iw; i++) exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd3);
    if (!br && (mr || mw)) for (int i = 0; i <= dw; i++) exp_q.push_back(3'd4);
    if (wb) exp_q.push_back(3'd5);
    k = 0; fi = 0; mi = 0; aborted = 1'b0;
    while (exp_q.size() > 0) begin
      es   = exp_q.pop_front();
      last = (exp_q.size() == 0);
      reset = (k == abort_at);
      start = 1'($urandom_range(0, 1));
      if (es == 3'd2) begin
        pc_src = p; mem_r = mr; mem_w = mw; reg_w = rw; stop = st;
      end else begin
        pc_src = 2'($urandom_range(0, 3)); mem_r = 1'($urandom_range(0, 1));
        mem_w = 1'($urandom_range(0, 1)); reg_w = 1'($urandom_range(0, 1));
        stop = 1'($urandom_range(0, 1));
      end
      imem_ready = (es == 3'd1) ? (fi == iw) : 1'($urandom_range(0, 1));
      dmem_ready = (es == 3'd4) ? (mi == dw) : 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("state", 32'(state), 32'(es));
      chk("small_state", 32'(s_state), 32'(es));
      chk("imem_req", 32'(imem_req), 32'(es == 3'd1));
      chk("ir_write", 32'(ir_write), 32'(es == 3'd1 && imem_ready));
      chk("reg_read_en", 32'(reg_read_en), 32'(es == 3'd2));
      chk("alu_en", 32'(alu_en), 32'(es == 3'd3));
      chk("dmem_req", 32'(dmem_req), 32'(es == 3'd4));
      chk("dmem_we", 32'(dmem_we), 32'(es == 3'd4 && mw));
      chk("reg_write_en", 32'(reg_write_en), 32'(es == 3'd5));
      chk("pc_write", 32'(pc_write), 32'(last));
      chk("small_pc_write", 32'(s_pc_write), 32'(last));
      chk("instr_retired", 32'(instr_retired), 32'(last));
      chk("pc_sel", 32'(pc_sel), (last && br) ? 32'(p) : 32'd0);
      chk("halted", 32'(halted), 32'd0);
      chk_counts();
      @(posedge clk); #1;
      if (es == 3'd1) fi++;
      if (es == 3'd4) mi++;
      if (reset) begin
        exp_q.delete();
        reset = 1'b0;
        aborted = 1'b1;
        model_count = 0;
      end else if (last) begin
        model_count++;
      end
      k++;
    end
    if (!aborted) chk("after_instr_state", 32'(state), st ? 32'd6 : 32'd1);
  endtask

  // Single IDLE cycle with start high.
  task automatic kick();
    start = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
    @(negedge clk);
    chk("idle_before_start", 32'(state), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pc_src = 2'b00; mem_r = 1'b0; mem_w = 1'b0;
    reg_w = 1'b0; stop = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_outputs", {imem_req, ir_write, reg_read_en, alu_en, dmem_req, dmem_we,
        reg_write_en, pc_write, pc_sel, instr_retired, halted}, 32'd0);
    chk_counts();
    @(posedge clk); #1;
    reset = 1'b0;

    // IDLE holds without start even with readies asserted.
    for (int i = 0; i < 2; i++) begin
      imem_ready = 1'b1; dmem_ready = 1'b1;
      @(negedge clk);
      chk("idle_hold", 32'(state), 32'd0);
      chk("idle_no_req", 32'(imem_req || dmem_req), 32'd0);
      @(posedge clk); #1;
    end
    kick();

    // Directed: ALU, load with 2 dmem waits, branch, store.
    run_instr(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, -1);
    run_instr(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 0, 2, -1);
    run_instr(2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0, -1);
    run_instr(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1, -1);
    run_instr(2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, -1);

    // Random instructions with random wait counts.
    for (int n = 0; n < 24; n++) begin
      logic [1:0] p;
      p = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_instr(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 2),
                $urandom_range(0, 2), -1);
    end

    // Store with stop set, then HALT ignores start.
    run_instr(2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, -1);
    for (int i = 0; i < 4; i++) begin
      start = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
      @(negedge clk);
      chk("halt_state", 32'(state), 32'd6);
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_enables", {imem_req, ir_write, reg_read_en, alu_en, dmem_req,
          dmem_we, reg_write_en, pc_write, instr_retired}, 32'd0);
      chk_counts();
      @(posedge clk); #1;
    end

    // Reset out of HALT, then reset in the second MEM cycle of a load.
    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_count = 0;
    @(negedge clk);
    chk("halt_reset_state", 32'(state), 32'd0);
    chk_counts();
    @(posedge clk); #1;
    kick();
    run_instr(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 0, 3, 4);
    start = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;
    @(negedge clk);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_dmem_req", 32'(dmem_req), 32'd0);
    chk("abort_imem_req", 32'(imem_req), 32'd0);
    chk("abort_retire", 32'(instr_retired || pc_write), 32'd0);
    chk_counts();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Moore/Mealy FSM that sequences the multi-cycle 32-bit datapath through FETCH, DECODE, EXEC, MEM and WB.
- Uses the class signals produced by the main controller (pcSrc, mem_R, mem_W, regW) and the decoder stop bit to pick the path for each instruction.
- Issues per-stage enables, and handles req/ready handshakes with instruction memory and data memory.
- Counts retired instructions and halts after an instruction whose stop bit is set.

Parameters:
- COUNT_W, 16, width of the retired-instruction counter (saturating).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; one clock, synchronous reset.
- start  input  1  leaves IDLE; ignored in every other state.
- pcSrc  input  2  from main controller; non-zero means control transfer.
- mem_R  input  1  from main controller; load.
- mem_W  input  1  from main controller; store.
- regW  input  1  from main controller; register write-back.
- stop  input  1  from instruction decoder; halt after this instruction.
- imem_ready  input  1  instruction memory data valid.
- dmem_ready  input  1  data memory access complete.
- imem_req  output  1  instruction fetch request.
- ir_write  output  1  load the instruction register.
- reg_read_en  output  1  register file read / operand latch.
- alu_en  output  1  ALU result register load.
- dmem_req  output  1  data memory request.
- dmem_we  output  1  data memory write (valid with dmem_req).
- reg_write_en  output  1  register file write.
- pc_write  output  1  PC update.
- pc_sel  output  2  PC source select; valid when pc_write=1.
- instr_retired  output  1  one-cycle pulse when an instruction completes.
- retired_count  output  COUNT_W  number of retired instructions.
- halted  output  1  high while in HALT.
- state  output  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.

Behaviour:
- Reset: state=IDLE, retired_count=0, all latched class bits=0, every output 0. Reset mid-instruction aborts immediately: imem_req and dmem_req drop in the cycle after reset is sampled, and no retire occurs.
- Class latch:
  - pcSrc, mem_R, mem_W, regW and stop are registered on the DECODE->EXEC edge.
  - Later states use only the latched copies; inputs may change after DECODE.
- IDLE: start=1 -> FETCH.
- FETCH:
  - imem_req=1.
  - ir_write = imem_ready (Mealy).
  - imem_ready=1 -> DECODE; otherwise stay, holding imem_req.
- DECODE: reg_read_en=1 -> EXEC, unconditionally.
- EXEC: alu_en=1, then by priority:
  1. pcSrc!=0 -> retire, with pc_sel=pcSrc.
  2. mem_R or mem_W -> MEM.
  3. regW -> WB.
  4. Otherwise -> retire, with pc_sel=0.
- MEM:
  - dmem_req=1; dmem_we = latched mem_W.
  - Hold until dmem_ready=1.
  - Then: latched mem_R and regW -> WB; otherwise retire.
  - mem_R and mem_W both set is treated as a store (dmem_we=1) with no WB.
- WB: reg_write_en=1 -> retire.
- Retire cycle (the state performing it):
  - pc_write=1 and instr_retired=1.
  - retired_count increments, saturating at 2^COUNT_W-1.
  - pc_sel = latched pcSrc for a branch, else 0.
  - Next state is HALT if latched stop=1, else FETCH.
- HALT: halted=1, all other enables 0. Only reset exits; start is ignored.
- Latency with ready asserted in the same cycle as req:
  - branch: 3 cycles
  - ALU/no-op: 3 or 4 cycles
  - store: 4 cycles
  - load: 5 cycles
  - Each wait cycle on imem_ready or dmem_ready adds 1.
- Simultaneous events: a ready arriving while its req is deasserted is ignored. No pc_write occurs outside a retire cycle.

Test Plan:
- Reset, then start=1 with an ALU instruction (regW=1, pcSrc=0, mem=0), imem_ready tied to 1 -> states 1,2,3,5. reg_write_en high in cycle 4; pc_write=1, pc_sel=0, retired_count=1.
- Load (mem_R=1, regW=1) with dmem_ready delayed 2 cycles -> MEM held 3 cycles with dmem_req=1, dmem_we=0; then WB; total 7 cycles; instr_retired pulses exactly once.
- Branch (pcSrc=2'b10) -> retire in EXEC with pc_write=1, pc_sel=2'b10. MEM and WB are never entered.
- Store with stop=1 -> dmem_we=1 in MEM, then retire, then HALT (halted=1, state=6). start pulsed afterwards has no effect.
- Reset asserted mid-MEM with dmem_req=1 -> next cycle state=0, dmem_req=0, retired_count=0.
- COUNT_W=2, 5 back-to-back no-op instructions -> retired_count reads 1,2,3,3,3.
